mem_arbiter: RTL

//  Shares one single-ported, variable-latency unified memory between the processor's

---
 rtl/rb_mem_pkg.sv | 7 +
 rtl/arb_watchdog.sv | 31 +++
 rtl/mem_arbiter.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/rb_mem_pkg.sv
// Shared types and defaults for the unified-memory arbiter.
//   arb_state_t  : arbiter FSM states
//   TIMEOUT_DEF  : default per-access watchdog limit in cycles
package rb_mem_pkg;
   typedef enum logic [2:0] {IDLE, LOAD, DATA, FETCH, STEP} arb_state_t;
   localparam int TIMEOUT_DEF = 64;
endpackage

// File: rtl/arb_watchdog.sv
// Per-access watchdog. Counts cycles while enabled and pulses o_Expire on the
// cycle where the count would reach TIMEOUT-1, so an access that never gets
// an ack is held for exactly TIMEOUT-1 cycles.
//   Clock, nReset : clock, async active-low reset
//   i_Clr         : restart count at 0 (takes priority over i_En)
//   i_En          : count this cycle
//   o_Expire      : limit reached this cycle
module arb_watchdog #(
   parameter int TIMEOUT = rb_mem_pkg::TIMEOUT_DEF
) (
   input  logic Clock,
   input  logic nReset,
   input  logic i_Clr,
   input  logic i_En,
   output logic o_Expire
);
   localparam int CW = $clog2(TIMEOUT);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset)    r_cnt <= '0;
      else if (i_Clr) r_cnt <= '0;
      else if (i_En)  r_cnt <= r_cnt + 1'b1;
   end

   // Compare against TIMEOUT-2: the increment at this edge is the one that
   // would reach TIMEOUT-1. Does not look at i_Clr, which is itself driven
   // from o_Expire in the arbiter.
   assign o_Expire = i_En && (r_cnt == CW'(TIMEOUT - 2));
endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-ported, variable-latency memory between
// instruction fetch, the processor's data access and a program loader.
// Each processor step runs IDLE -> [DATA] -> FETCH -> STEP; CpuHold is low
// only in STEP. A loader write (LdReq) wins arbitration in IDLE.
//   Clock, nReset            : clock, async active-low reset
//   InstrAddr / InstrMem     : fetch address in / fetched word out (reg)
//   MemAddr, MemRead, MemWrite, WriteData, WriteL, WriteR : data access in
//   MemData                  : last completed read data (reg)
//   CpuHold                  : 1 = processor must not advance
//   LdReq, LdAddr, LdData    : loader write request (level)
//   LdAck                    : loader write accepted (one-cycle pulse)
//   MReq, MWe, MAddr, MWData, MWL, MWR : memory request side (reg)
//   MAck, MRData             : memory completion and read data
//   Err                      : sticky access-timeout flag
module mem_arbiter
   import rb_mem_pkg::*;
#(
   parameter int AW      = 16,
   parameter int DW      = 32,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic          Clock,
   input  logic          nReset,
   input  logic [AW-1:0] InstrAddr,
   output logic [DW-1:0] InstrMem,
   input  logic [AW-1:0] MemAddr,
   input  logic          MemRead,
   input  logic          MemWrite,
   input  logic [DW-1:0] WriteData,
   input  logic          WriteL,
   input  logic          WriteR,
   output logic [DW-1:0] MemData,
   output logic          CpuHold,
   input  logic          LdReq,
   input  logic [AW-1:0] LdAddr,
   input  logic [DW-1:0] LdData,
   output logic          LdAck,
   output logic          MReq,
   output logic          MWe,
   output logic [AW-1:0] MAddr,
   output logic [DW-1:0] MWData,
   output logic          MWL,
   output logic          MWR,
   input  logic          MAck,
   input  logic [DW-1:0] MRData,
   output logic          Err
);
   arb_state_t    r_state;
   logic [AW-1:0] r_iaddr;
   logic          r_rd, r_wr;
   logic [DW-1:0] r_instr, r_mdata, r_mwdata;
   logic [AW-1:0] r_maddr;
   logic          r_hold, r_mreq, r_mwe, r_mwl, r_mwr, r_err;

   logic w_in_acc, w_ack, w_expire, w_done, w_to;

   assign w_in_acc = (r_state == LOAD) || (r_state == DATA) || (r_state == FETCH);
   assign w_ack    = r_mreq && MAck;            // acks with no request are ignored
   assign w_done   = w_ack || w_expire;
   assign w_to     = w_expire && !w_ack;        // a late ack on the last cycle still counts

   arb_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
      .Clock    (Clock),
      .nReset   (nReset),
      .i_Clr    (!w_in_acc || w_done),
      .i_En     (w_in_acc),
      .o_Expire (w_expire)
   );

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         r_state  <= IDLE;
         r_iaddr  <= '0;
         r_rd     <= 1'b0;
         r_wr     <= 1'b0;
         r_instr  <= '0;
         r_mdata  <= '0;
         r_hold   <= 1'b1;
         r_mreq   <= 1'b0;
         r_mwe    <= 1'b0;
         r_maddr  <= '0;
         r_mwdata <= '0;
         r_mwl    <= 1'b0;
         r_mwr    <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_mreq <= 1'b1;
               if (LdReq) begin
                  r_state  <= LOAD;
                  r_mwe    <= 1'b1;
                  r_maddr  <= LdAddr;
                  r_mwdata <= LdData;
                  r_mwl    <= 1'b0;
                  r_mwr    <= 1'b0;
               end else begin
                  // Processor inputs are captured only here; the memory
                  // request registers double as the data-access latch.
                  r_iaddr <= InstrAddr;
                  r_rd    <= MemRead;
                  r_wr    <= MemWrite;
                  if (MemRead || MemWrite) begin
                     r_state  <= DATA;
                     r_mwe    <= MemWrite;   // read+write resolves to a write
                     r_maddr  <= MemAddr;
                     r_mwdata <= WriteData;
                     r_mwl    <= WriteL;
                     r_mwr    <= WriteR;
                  end else begin
                     r_state <= FETCH;
                     r_mwe   <= 1'b0;
                     r_maddr <= InstrAddr;
                     r_mwl   <= 1'b0;
                     r_mwr   <= 1'b0;
                  end
               end
            end
            DATA: if (w_done) begin
               if (r_rd && !r_wr) r_mdata <= w_ack ? MRData : '0;
               if (w_to)          r_err   <= 1'b1;
               // Fetch goes out after the data access so a store to the
               // fetch address is seen by this step's fetch.
               r_state <= FETCH;
               r_mreq  <= 1'b1;
               r_mwe   <= 1'b0;
               r_maddr <= r_iaddr;
               r_mwl   <= 1'b0;
               r_mwr   <= 1'b0;
            end
            FETCH: if (w_done) begin
               r_instr <= w_ack ? MRData : '0;       // aborted fetch becomes a NOP
               if (w_to) r_err <= 1'b1;
               r_state <= STEP;
               r_mreq  <= 1'b0;
               r_mwe   <= 1'b0;
               r_hold  <= 1'b0;
            end
            LOAD: if (w_done) begin
               if (w_to) r_err <= 1'b1;
               r_state <= IDLE;
               r_mreq  <= 1'b0;
               r_mwe   <= 1'b0;
            end
            STEP: begin
               r_hold  <= 1'b1;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign LdAck    = (r_state == LOAD) && w_done;
   assign InstrMem = r_instr;
   assign MemData  = r_mdata;
   assign CpuHold  = r_hold;
   assign MReq     = r_mreq;
   assign MWe      = r_mwe;
   assign MAddr    = r_maddr;
   assign MWData   = r_mwdata;
   assign MWL      = r_mwl;
   assign MWR      = r_mwr;
   assign Err      = r_err;
endmodule
